id_ex_pipe_reg: RTL

- ID/EX boundary register of the 5-stage RV32I pipeline.
- Captures the ID-stage control bundle (ALU source selects, imm type, alu_op, branch flags, memory/writeback enables) together with PC, operands, immediate and register addresses, and presents them to EX.
- Contains the load-use hazard detector: it inserts a single-cycle bubble and stalls IF/ID.
- Honours branch flush and EX hold, and keeps saturating bubble/flush performance counters.

---
 rtl/id_ex_pipe_reg.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX boundary register for the 5-stage RV32I pipeline.
// Holds the decoded control bundle and operands for EX, detects load-use
// hazards (one-cycle bubble plus an upstream stall), honours branch flush
// and EX hold, and keeps saturating bubble/flush counters.
//
// Handshake: there is no valid/ready pair here. valid_ex qualifies every
// *_ex field. The register advances on every clock edge unless ex_hold
// freezes it. stall_upstream tells PC/IF-ID to hold their contents this
// cycle, and is combinational from the current inputs.
module id_ex_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_id,
  input  logic [XLEN-1:0]  pc_id,
  input  logic [XLEN-1:0]  rs1_data_id,
  input  logic [XLEN-1:0]  rs2_data_id,
  input  logic [XLEN-1:0]  imm_id,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [4:0]       rd_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic             alu_src1_is_pc_id,
  input  logic             alu_src2_is_imm_id,
  input  logic             alu_src2_is_4_id,
  input  logic [2:0]       imm_type_id,
  input  logic [1:0]       alu_op_id,
  input  logic             br_jal_id,
  input  logic             br_beq_id,
  input  logic             br_blt_id,
  input  logic             br_bltu_id,
  input  logic             mem_to_reg_id,
  input  logic             reg_w_en_id,
  input  logic             dm_w_en_id,
  input  logic             dm_r_en_id,
  input  logic             flush,
  input  logic             ex_hold,
  output logic             valid_ex,
  output logic [XLEN-1:0]  pc_ex,
  output logic [XLEN-1:0]  rs1_data_ex,
  output logic [XLEN-1:0]  rs2_data_ex,
  output logic [XLEN-1:0]  imm_ex,
  output logic [4:0]       rs1_ex,
  output logic [4:0]       rs2_ex,
  output logic [4:0]       rd_ex,
  output logic             rs1_used_ex,
  output logic             rs2_used_ex,
  output logic             alu_src1_is_pc_ex,
  output logic             alu_src2_is_imm_ex,
  output logic             alu_src2_is_4_ex,
  output logic [2:0]       imm_type_ex,
  output logic [1:0]       alu_op_ex,
  output logic             br_jal_ex,
  output logic             br_beq_ex,
  output logic             br_blt_ex,
  output logic             br_bltu_ex,
  output logic             mem_to_reg_ex,
  output logic             reg_w_en_ex,
  output logic             dm_w_en_ex,
  output logic             dm_r_en_ex,
  output logic             stall_upstream,
  output logic             load_use_hazard,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // One packed record so a bubble is simply all-zero.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rs1_used;
    logic            rs2_used;
    logic            src1_is_pc;
    logic            src2_is_imm;
    logic            src2_is_4;
    logic [2:0]      imm_type;
    logic [1:0]      alu_op;
    logic            br_jal;
    logic            br_beq;
    logic            br_blt;
    logic            br_bltu;
    logic            mem_to_reg;
    logic            reg_w_en;
    logic            dm_w_en;
    logic            dm_r_en;
  } stage_t;

  stage_t           id_s;
  stage_t           ex_d, ex_q;
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
  logic             hazard;
  logic             src_match;

  assign id_s = '{
    valid:       valid_id,
    pc:          pc_id,
    rs1_data:    rs1_data_id,
    rs2_data:    rs2_data_id,
    imm:         imm_id,
    rs1:         rs1_id,
    rs2:         rs2_id,
    rd:          rd_id,
    rs1_used:    rs1_used_id,
    rs2_used:    rs2_used_id,
    src1_is_pc:  alu_src1_is_pc_id,
    src2_is_imm: alu_src2_is_imm_id,
    src2_is_4:   alu_src2_is_4_id,
    imm_type:    imm_type_id,
    alu_op:      alu_op_id,
    br_jal:      br_jal_id,
    br_beq:      br_beq_id,
    br_blt:      br_blt_id,
    br_bltu:     br_bltu_id,
    mem_to_reg:  mem_to_reg_id,
    reg_w_en:    reg_w_en_id,
    dm_w_en:     dm_w_en_id,
    dm_r_en:     dm_r_en_id
  };

  // Load in EX whose destination is read by the instruction in ID; x0 never hazards.
  always_comb begin
    src_match = (rs1_used_id && (rs1_id == ex_q.rd)) ||
                (rs2_used_id && (rs2_id == ex_q.rd));
    hazard    = valid_id && ex_q.valid && ex_q.dm_r_en && ex_q.reg_w_en &&
                (ex_q.rd != 5'd0) && src_match;
  end

  assign load_use_hazard = hazard;
  assign stall_upstream  = !flush && (ex_hold || hazard);

  // Next-state: flush beats hold, hold beats hazard bubble, else advance.
  always_comb begin
    ex_d         = ex_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (flush) begin
      ex_d = '0;
      if (flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (ex_hold) begin
      ex_d = ex_q;
    end else if (hazard) begin
      ex_d = '0;
      if (bubble_cnt_q != {CNT_W{1'b1}}) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end else begin
      ex_d = id_s;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign valid_ex           = ex_q.valid;
  assign pc_ex              = ex_q.pc;
  assign rs1_data_ex        = ex_q.rs1_data;
  assign rs2_data_ex        = ex_q.rs2_data;
  assign imm_ex             = ex_q.imm;
  assign rs1_ex             = ex_q.rs1;
  assign rs2_ex             = ex_q.rs2;
  assign rd_ex              = ex_q.rd;
  assign rs1_used_ex        = ex_q.rs1_used;
  assign rs2_used_ex        = ex_q.rs2_used;
  assign alu_src1_is_pc_ex  = ex_q.src1_is_pc;
  assign alu_src2_is_imm_ex = ex_q.src2_is_imm;
  assign alu_src2_is_4_ex   = ex_q.src2_is_4;
  assign imm_type_ex        = ex_q.imm_type;
  assign alu_op_ex          = ex_q.alu_op;
  assign br_jal_ex          = ex_q.br_jal;
  assign br_beq_ex          = ex_q.br_beq;
  assign br_blt_ex          = ex_q.br_blt;
  assign br_bltu_ex         = ex_q.br_bltu;
  assign mem_to_reg_ex      = ex_q.mem_to_reg;
  assign reg_w_en_ex        = ex_q.reg_w_en;
  assign dm_w_en_ex         = ex_q.dm_w_en;
  assign dm_r_en_ex         = ex_q.dm_r_en;
  assign bubble_cnt         = bubble_cnt_q;
  assign flush_cnt          = flush_cnt_q;

endmodule
